// File: rtl/hazard_sched.sv
// hazard_sched: E/M/W scoreboard, forwarding, stall/squash control, perf counters.
// Build option: define HAZ_FWD_EN for forwarding with load-use-only stalls.
module hazard_sched #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             de_valid,
   input  logic [31:0]      instr_de,
   input  logic             br_taken_exe,
   input  logic             mem_busy,
   output logic             stall_f,
   output logic             stall_d,
   output logic             bubble_e,
   output logic             flush_d,
   output logic             freeze,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef struct packed {
      logic       valid;
      logic       wb_en;
      logic       is_load;
      logic [4:0] rd;
   } sb_t;

   typedef enum logic {
      RUN,
      SQ2
   } state_t;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_OP    = 7'b0110011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_ST    = 7'b0100011;

   sb_t              e_q, m_q, w_q, e_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic [6:0] opc;
   logic [4:0] rs1, rs2, rd;
   logic       dec_wr, dec_ld, use1, use2;
   logic       a_e, a_m, a_w, b_e, b_m, b_w;
   logic       dstall, squash;
   logic       unused_bits;

   assign opc = instr_de[6:0];
   assign rd  = instr_de[11:7];
   assign rs1 = instr_de[19:15];
   assign rs2 = instr_de[24:20];

   always_comb begin
      dec_wr = 1'b0;
      dec_ld = 1'b0;
      use1   = 1'b0;
      use2   = 1'b0;
      unique case (opc)
         OP_LUI, OP_AUIPC, OP_JAL: dec_wr = 1'b1;
         OP_JALR, OP_IMM: begin
            dec_wr = 1'b1;
            use1   = 1'b1;
         end
         OP_LOAD: begin
            dec_wr = 1'b1;
            dec_ld = 1'b1;
            use1   = 1'b1;
         end
         OP_OP: begin
            dec_wr = 1'b1;
            use1   = 1'b1;
            use2   = 1'b1;
         end
         OP_BR, OP_ST: begin
            use1 = 1'b1;
            use2 = 1'b1;
         end
         default: ;
      endcase
   end

   function automatic logic hit(sb_t s, logic [4:0] rs, logic used);
      return used && s.valid && s.wb_en && (s.rd != 5'd0) && (s.rd == rs);
   endfunction

   assign a_e = hit(e_q, rs1, use1 & de_valid);
   assign a_m = hit(m_q, rs1, use1 & de_valid);
   assign a_w = hit(w_q, rs1, use1 & de_valid);
   assign b_e = hit(e_q, rs2, use2 & de_valid);
   assign b_m = hit(m_q, rs2, use2 & de_valid);
   assign b_w = hit(w_q, rs2, use2 & de_valid);

`ifdef HAZ_FWD_EN
   function automatic logic [1:0] fsel(logic e, logic m, logic w, logic eld);
      if (e && !eld) return 2'b01;
      if (m)         return 2'b10;
      if (w)         return 2'b11;
      return 2'b00;
   endfunction

   assign dstall    = (a_e | b_e) & e_q.is_load;
   assign fwd_a_sel = fsel(a_e, a_m, a_w, e_q.is_load);
   assign fwd_b_sel = fsel(b_e, b_m, b_w, e_q.is_load);
`else
   // No bypass network: wait until the producer has left W.
   assign dstall    = a_e | a_m | a_w | b_e | b_m | b_w;
   assign fwd_a_sel = 2'b00;
   assign fwd_b_sel = 2'b00;
`endif

   assign squash = (state_q == SQ2) | br_taken_exe;

   always_comb begin
      stall_f     = 1'b0;
      stall_d     = 1'b0;
      bubble_e    = 1'b0;
      flush_d     = 1'b0;
      freeze      = 1'b0;
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (mem_busy) begin
         freeze  = 1'b1;
         stall_f = 1'b1;
         stall_d = 1'b1;
      end else if (squash) begin
         flush_d  = 1'b1;
         bubble_e = 1'b1;
         if (state_q == RUN) begin
            state_d = SQ2;
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end else begin
            state_d = RUN;
         end
      end else if (dstall) begin
         stall_f  = 1'b1;
         stall_d  = 1'b1;
         bubble_e = 1'b1;
         if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      e_d = '0;
      if (de_valid && !bubble_e && !flush_d) begin
         e_d = '{valid: 1'b1, wb_en: dec_wr, is_load: dec_ld, rd: rd};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_q         <= '0;
         m_q         <= '0;
         w_q         <= '0;
         state_q     <= RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else if (!mem_busy) begin
         w_q         <= m_q;
         m_q         <= e_q;
         e_q         <= e_d;
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

   assign unused_bits = ^{instr_de[31:25], instr_de[14:12],
                          w_q.is_load, e_q.is_load};

endmodule

// File: doc/hazard_sched.md
# hazard_sched

Pipeline hazard scheduler for the rv32 five-stage core (F/D/E/M/W). It shadows the destination registers of the instructions in E, M and W in a small scoreboard and decodes the D-stage instruction. Each cycle it drives the stall, bubble, flush and operand-forwarding controls for the datapath. It also sequences the branch-redirect squash, honours data-memory back-pressure and keeps saturating stall/flush performance counters.

## Interface
- CNT_W, 16, width of each performance counter

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- de_valid  in  1  D-stage holds a valid instruction
- instr_de  in  32  D-stage instruction word
- br_taken_exe  in  1  E-stage branch/JAL/JALR resolved taken; PC redirected this cycle
- mem_busy  in  1  data memory not ready; M-stage must hold
- stall_f  out  1  hold PC/fetch register
- stall_d  out  1  hold D register
- bubble_e  out  1  load NOP into E at next edge
- flush_d  out  1  squash D register at next edge
- freeze  out  1  hold E, M and W registers
- fwd_a_sel  out  2  rs1 operand source: 00 regfile, 01 E result, 10 M result, 11 W result
- fwd_b_sel  out  2  rs2 operand source, same encoding
- stall_cnt  out  CNT_W  cycles with a data-hazard stall, saturating
- flush_cnt  out  CNT_W  branch-redirect events, saturating

## Operation
- **Decode of instr_de[6:0]**
  - Writes rd: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, LOAD 0000011, OP-IMM 0010011, OP 0110011.
  - Does not write rd: BRANCH 1100011, STORE 0100011, all other opcodes.
  - Uses rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Uses rs2: BRANCH, STORE, OP.
  - is_load is set for LOAD.
- **Scoreboard**: per stage E/M/W holds {valid, wb_en, is_load, rd[4:0]}.
- **Match(stage, rs)**: valid && wb_en && rd!=0 && rd==rs && the rs is used by instr_de && de_valid.
- **Priority** (highest first):
  1. mem_busy: freeze=1, stall_f=1, stall_d=1. bubble_e=0, flush_d=0. Scoreboard, FSM and counters hold.
  2. Branch squash (FSM below): flush_d=1, bubble_e=1. No data stall is raised.
  3. Data stall: stall_f=1, stall_d=1, bubble_e=1. stall_cnt increments.
- **Data stall condition**: Match(E, rs1 or rs2) with E.is_load (load-use).
- **Forwarding**, per operand: E match with !is_load gives 01; else M match gives 10; else W match gives 11; else 00. fwd_*_sel is valid even during a stall.
- **Scoreboard advance** at each edge with !mem_busy:
  - W<=M and M<=E.
  - E<=decoded D info when de_valid && !bubble_e && !flush_d; otherwise E.valid<=0.
- **Squash FSM**:
  - RUN: br_taken_exe && !mem_busy drives squash this cycle and moves to SQ2; flush_cnt increments.
  - SQ2: flush_d=1 (the fetched wrong-path instruction), bubble_e=1, then returns to RUN. mem_busy holds SQ2.
  - br_taken_exe in SQ2 is ignored, because E holds a bubble.
- **Counters**: saturate at all-ones and never wrap.

## Timing
- All control outputs are combinational from the inputs and registered state, with no added latency.
- The scoreboard, FSM and counters update on the posedge of clk.
- **Reset values**: scoreboard valid bits 0, FSM RUN, counters 0. All stall/flush/bubble/freeze outputs are 0 and fwd_*_sel are 00.
- **Reset mid-stall or mid-squash**: everything returns to reset values immediately (asynchronous). The first post-reset edge loads E from D.
- **Load-use penalty**: exactly 1 cycle. On the next cycle the load is in M and the operand forwards with 10.
- **Branch penalty**: exactly 2 squashed slots (cycle of br_taken_exe plus SQ2).
- **mem_busy held N cycles**: every output other than freeze/stall_f/stall_d is held for N cycles. The pending squash or stall resumes afterwards.

## Configuration
- **HAZ_FWD_EN defined**: forwarding and stalling behave as above.
- **HAZ_FWD_EN undefined**:
  - fwd_a_sel and fwd_b_sel are tied to 00.
  - The data stall condition becomes any Match in E, M or W, load or not. This gives up to 3 stall cycles per dependency.
  - The regfile must not need write-through for this mode to be correct.

## Test plan
- Load x5 followed by add x6,x5,x1 -> 1 cycle with stall_f/stall_d/bubble_e=1, then fwd_a_sel=10; stall_cnt=1.
- addi x5 then add x7,x5,x5 back-to-back -> no stall; fwd_a_sel=fwd_b_sel=01. With rd=x0, both selects are 00.
- br_taken_exe pulse -> flush_d=1 and bubble_e=1 for 2 consecutive cycles; flush_cnt=1; no stall raised even with a pending load-use.
- mem_busy high for 3 cycles during SQ2 -> freeze=1 for those 3 cycles, scoreboard unchanged. SQ2 completes on the cycle after mem_busy drops.
- rst asserted mid-load-use stall -> all outputs 0 and fwd 00 immediately; counters 0.
- HAZ_FWD_EN undefined: addi x5 then add x6,x5,x0 -> 3 stall cycles, then proceed; stall_cnt=3.
